rd_empty_gen: RTL and testbench
===============================

RD_EMPTY_GEN -- requirements
Module: rd_empty_gen

Interface
REQ-001 Parameter: ADDR_WIDTH, default 4, FIFO depth is 2**ADDR_WIDTH and pointers are ADDR_WIDTH+1 bits.
REQ-002 Parameter: AEMPTY_TH, default 2, almost-empty threshold in words.
REQ-003 rd_clk_emp  input  1  read-domain clock; all state updates on its rising edge.
REQ-004 rst_n_rd_emp_in  input  1  reset, synchronous and active-low.
REQ-005 rd_en_emp  input  1  read request from the consumer.
REQ-006 wr_ptr_gray_emp_in  input  ADDR_WIDTH+1  write pointer, Gray coded, asynchronous to rd_clk_emp.
REQ-007 rd_addr_emp  output  ADDR_WIDTH  memory read address, the low bits of the binary read pointer.
REQ-008 rd_ptr_gray_emp  output  ADDR_WIDTH+1  registered Gray read pointer sent to the write domain.
REQ-009 empty_emp  output  1  registered FIFO-empty flag.
REQ-010 almost_empty_emp  output  1  registered; occupancy <= AEMPTY_TH.
REQ-011 rd_count_emp  output  ADDR_WIDTH+1  registered occupancy as seen by the read domain.
REQ-012 rd_valid_emp  output  1  one-cycle pulse for a read accepted on the previous edge.
REQ-013 underflow_emp  output  1  one-cycle pulse for a read requested while empty_emp=1.

Function
REQ-014 Synchroniser: a two-flop chain (sync1 -> sync2) samples wr_ptr_gray_emp_in; no other logic reads wr_ptr_gray_emp_in.
REQ-015 Accept rule: rd_inc = rd_en_emp AND NOT empty_emp.
REQ-016 Binary pointer: rd_bin_next = rd_bin + rd_inc, modulo 2**(ADDR_WIDTH+1); it wraps from all-ones to 0 with no other effect.
REQ-017 Gray pointer: rd_gray_next = rd_bin_next XOR (rd_bin_next >> 1); rd_ptr_gray_emp registers rd_gray_next.
REQ-018 Address: rd_addr_emp = rd_bin[ADDR_WIDTH-1:0]; it advances on the same edge that accepts the read.
REQ-019 Empty: empty_emp registers (rd_gray_next == sync2); it asserts on the edge that accepts the last word.
REQ-020 Occupancy: wr_bin_sync = Gray-to-binary(sync2); rd_count_emp registers (wr_bin_sync - rd_bin_next) mod 2**(ADDR_WIDTH+1).
REQ-021 Almost empty: almost_empty_emp registers (occupancy_next <= AEMPTY_TH), where occupancy_next is the value being loaded into rd_count_emp.
REQ-022 rd_valid_emp registers rd_inc; underflow_emp registers (rd_en_emp AND empty_emp).
REQ-023 Latency: a change on wr_ptr_gray_emp_in is reflected in empty_emp, almost_empty_emp and rd_count_emp on the 3rd rising edge after it becomes stable.
REQ-024 Simultaneous write and read: pointer and flag updates use rd_bin_next and the current sync2 in the same cycle; no read is lost and no read is duplicated.
REQ-025 A read request while empty_emp=1 leaves rd_bin, rd_addr_emp and rd_ptr_gray_emp unchanged.
REQ-026 rd_count_emp never exceeds 2**ADDR_WIDTH when the write side obeys its full flag.

Reset
REQ-027 When rst_n_rd_emp_in=0 at a rising edge, the block clears rd_bin, rd_ptr_gray_emp, sync1, sync2, rd_addr_emp, rd_count_emp, rd_valid_emp and underflow_emp to 0, and sets empty_emp and almost_empty_emp to 1.
REQ-028 Reset has priority over rd_en_emp; reset asserted mid-stream discards pointer state on that edge.
REQ-029 The first read can be accepted no earlier than the 3rd edge after reset release that follows a nonzero write pointer.

Verification
REQ-030 The bench shall cover the following scenarios:
- Reset, then rd_en_emp=1 with wr_ptr_gray_emp_in=0 -> empty_emp=1, underflow_emp pulses every cycle, and rd_addr_emp stays 0.
- wr_ptr_gray_emp_in set to Gray(3)=00010 -> on the 3rd edge empty_emp=0 and rd_count_emp=3. Then 3 reads -> rd_addr_emp goes 1, 2, 3, rd_valid_emp shows 3 pulses, and empty_emp=1 on the edge of the 3rd read.
- AEMPTY_TH=2 with write pointer = 5 and reads one per cycle -> almost_empty_emp=0 at count 5, 4 and 3, then 1 at count 2.
- Write pointer stepped in Gray sequence to 31 and then 0 (wrap), with continuous reads -> rd_bin wraps 31 to 0, rd_ptr_gray_emp goes 10000 to 00000, and the total number of accepted reads equals the number of writes.
- Reset asserted after 4 of 8 reads -> on the next edge all outputs hold their reset values and rd_ptr_gray_emp=0.
- Write pointer and read advancing in the same cycle at count 1 -> empty_emp stays 0 and rd_count_emp stays 1.

Source files
------------

// File: rtl/rd_empty_gen.sv
// Read-side empty/occupancy generator for an async FIFO.
// Synchronises the Gray write pointer and keeps the read pointer.
module rd_empty_gen #(
  parameter int ADDR_WIDTH = 4,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  rd_clk_emp,
  input  logic                  rst_n_rd_emp_in,
  input  logic                  rd_en_emp,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray_emp_in,
  output logic [ADDR_WIDTH-1:0] rd_addr_emp,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray_emp,
  output logic                  empty_emp,
  output logic                  almost_empty_emp,
  output logic [ADDR_WIDTH:0]   rd_count_emp,
  output logic                  rd_valid_emp,
  output logic                  underflow_emp
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] TH = PW'(AEMPTY_TH);

  logic [ADDR_WIDTH:0] sync1;
  logic [ADDR_WIDTH:0] sync2;
  logic [ADDR_WIDTH:0] rd_bin;
  logic [ADDR_WIDTH:0] rd_bin_next;
  logic [ADDR_WIDTH:0] rd_gray_next;
  logic [ADDR_WIDTH:0] wr_bin_sync;
  logic [ADDR_WIDTH:0] occ_next;
  logic                rd_inc;

  assign rd_inc       = rd_en_emp & ~empty_emp;
  assign rd_bin_next  = rd_bin + {{ADDR_WIDTH{1'b0}}, rd_inc};
  assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
  assign rd_addr_emp  = rd_bin[ADDR_WIDTH-1:0];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wr_bin_sync = '0;
    for (int i = 0; i < PW; i++) begin
      wr_bin_sync[i] = ^(sync2 >> i);
    end
  end

  assign occ_next = wr_bin_sync - rd_bin_next;

  always_ff @(posedge rd_clk_emp) begin
    if (!rst_n_rd_emp_in) begin
      sync1            <= '0;
      sync2            <= '0;
      rd_bin           <= '0;
      rd_ptr_gray_emp  <= '0;
      empty_emp        <= 1'b1;
      almost_empty_emp <= 1'b1;
      rd_count_emp     <= '0;
      rd_valid_emp     <= 1'b0;
      underflow_emp    <= 1'b0;
    end else begin
      sync1            <= wr_ptr_gray_emp_in;
      sync2            <= sync1;
      rd_bin           <= rd_bin_next;
      rd_ptr_gray_emp  <= rd_gray_next;
      empty_emp        <= (rd_gray_next == sync2);
      almost_empty_emp <= (occ_next <= TH);
      rd_count_emp     <= occ_next;
      rd_valid_emp     <= rd_inc;
      underflow_emp    <= rd_en_emp & empty_emp;
    end
  end

endmodule

// File: tb/tb_rd_empty_gen.sv
// Bench for rd_empty_gen: directed scenarios plus random traffic
// checked against an integer pointer model.
module tb_rd_empty_gen;

  localparam int AW  = 4;
  localparam int MOD = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_en;
  logic [AW:0]   wr_gray;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_gray;
  logic          empty;
  logic          aempty;
  logic [AW:0]   count;
  logic          valid;
  logic          uflow;

  rd_empty_gen #(.ADDR_WIDTH(AW), .AEMPTY_TH(2)) dut (
    .rd_clk_emp         (clk),
    .rst_n_rd_emp_in    (rst_n),
    .rd_en_emp          (rd_en),
    .wr_ptr_gray_emp_in (wr_gray),
    .rd_addr_emp        (rd_addr),
    .rd_ptr_gray_emp    (rd_gray),
    .empty_emp          (empty),
    .almost_empty_emp   (aempty),
    .rd_count_emp       (count),
    .rd_valid_emp       (valid),
    .underflow_emp      (uflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: integer pointers, two-stage delay of the write count
  int m_rd, m_s1, m_s2, m_cnt;
  bit m_empty, m_ae, m_valid, m_uf;
  int reads_seen;

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = AW'(0);
    v = (AW+1)'(b % MOD);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("empty", 32'(empty), 32'(m_empty));
    chk("aempty", 32'(aempty), 32'(m_ae));
    chk("count", 32'(count), 32'(m_cnt));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("uflow", 32'(uflow), 32'(m_uf));
    chk("addr", 32'(rd_addr), 32'(m_rd % 16));
    chk("rgray", 32'(rd_gray), 32'(gray(m_rd)));
  endtask

  task automatic step(input bit rst, input bit en, input int wr);
    bit acc;
    rst_n   = rst;
    rd_en   = en;
    wr_gray = gray(wr);
    @(posedge clk);
    if (!rst) begin
      m_rd = 0; m_s1 = 0; m_s2 = 0; m_cnt = 0;
      m_empty = 1; m_ae = 1; m_valid = 0; m_uf = 0;
    end else begin
      acc     = en && !m_empty;
      m_uf    = en && m_empty;
      m_valid = acc;
      m_rd    = (m_rd + int'(acc)) % MOD;
      m_empty = (m_rd == m_s2);
      m_cnt   = (m_s2 - m_rd + MOD) % MOD;
      m_ae    = (m_cnt <= 2);
      m_s2    = m_s1;
      m_s1    = wr % MOD;
    end
    #1;
    if (valid === 1'b1) reads_seen++;
    check_all();
  endtask

  initial begin
    int wr;
    int base;
    rst_n = 1'b0; rd_en = 1'b0; wr_gray = '0;
    reads_seen = 0;

    // reset state, then reads against an empty FIFO
    step(0, 0, 0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(aempty), 32'd1);
    for (int i = 0; i < 5; i++) step(1, 1, 0);
    chk("uf_pulse", 32'(uflow), 32'd1);
    chk("uf_addr", 32'(rd_addr), 32'd0);

    // three words become visible on the 3rd edge
    step(1, 0, 3);
    step(1, 0, 3);
    chk("lat_still_empty", 32'(empty), 32'd1);
    step(1, 0, 3);
    chk("lat_empty", 32'(empty), 32'd0);
    chk("lat_count", 32'(count), 32'd3);
    reads_seen = 0;
    for (int i = 1; i <= 3; i++) begin
      step(1, 1, 3);
      chk("rd_addr_seq", 32'(rd_addr), 32'(i));
    end
    chk("last_empty", 32'(empty), 32'd1);
    chk("three_valid", 32'(reads_seen), 32'd3);

    // stepping write pointer through the wrap with continuous reads
    reads_seen = 0;
    for (wr = 4; wr <= 32; wr++) step(1, 1, wr);
    for (int i = 0; i < 4; i++) step(1, 1, 32);
    chk("wrap_reads", 32'(reads_seen), 32'd29);
    chk("wrap_gray", 32'(rd_gray), 32'd0);
    chk("wrap_empty", 32'(empty), 32'd1);

    // write advancing with a read at count 1
    for (int i = 0; i < 3; i++) step(1, 0, 1);
    chk("c1_count", 32'(count), 32'd1);
    step(1, 0, 2);
    step(1, 0, 2);
    step(1, 1, 2);
    chk("c1_empty", 32'(empty), 32'd0);
    chk("c1_count_kept", 32'(count), 32'd1);

    // almost-empty threshold
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 5);
    chk("ae_c5", 32'(aempty), 32'd0);
    step(1, 1, 5);
    chk("ae_c4", 32'(aempty), 32'd0);
    step(1, 1, 5);
    chk("ae_c3", 32'(aempty), 32'd0);
    step(1, 1, 5);
    chk("ae_c2", 32'(aempty), 32'd1);
    chk("ae_cnt2", 32'(count), 32'd2);

    // reset mid-stream
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8);
    for (int i = 0; i < 4; i++) step(1, 1, 8);
    chk("mid_addr", 32'(rd_addr), 32'd4);
    step(0, 1, 8);
    chk("mid_rgray", 32'(rd_gray), 32'd0);
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_valid", 32'(valid), 32'd0);

    // random traffic; writer never exceeds 16 words ahead
    step(0, 0, 0);
    wr = 0;
    base = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1 && (wr - base) < 16) wr++;
      step(1, 1'($urandom_range(0, 1)), wr);
      if (m_valid) base++;
    end
    for (int i = 0; i < 25; i++) step(1, 1, wr);
    chk("rand_drained", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
